// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
// JESD204 TX transport-layer framer: packs per-channel DAC samples into lane octets,
// with sync arming/gating, zero/ramp test patterns and underflow detection.
//
// state    | meaning
// ST_IDLE  | stopped, zero beats, waiting for sync_arm
// ST_ARMED | armed, zero beats, waiting for a rising edge on dac_external_sync
// ST_RUN   | streaming the source picked by data_sel
module ad_ip_jesd204_tpl_dac_framer #(
    parameter int NUM_LANES         = 4,
    parameter int NUM_CHANNELS      = 4,
    parameter int SAMPLES_PER_FRAME = 1,
    parameter int BITS_PER_SAMPLE   = 16,
    parameter int OCTETS_PER_BEAT   = 4,
    parameter int DATA_PATH_WIDTH   = 2
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    dac_valid,
    output logic                                    dac_ready,
    input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] dac_data,
    input  logic                                    link_ready,
    output logic                                    link_valid,
    output logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] link_data,
    input  logic [1:0]                              data_sel,
    input  logic                                    ext_sync_en,
    input  logic                                    sync_arm,
    input  logic                                    sync_disarm,
    input  logic                                    dac_external_sync,
    output logic                                    sync_status,
    output logic                                    dac_dunf,
    output logic [15:0]                             dunf_count
);

    localparam int DATA_W     = NUM_LANES * 8 * OCTETS_PER_BEAT;
    localparam int NP         = BITS_PER_SAMPLE;
    localparam int NP_OCT     = NP / 8;
    localparam int CONV_OCT   = SAMPLES_PER_FRAME * NP_OCT;
    localparam int FRAME_OCT  = NUM_CHANNELS * CONV_OCT;
    localparam int F          = FRAME_OCT / NUM_LANES;
    localparam int NUM_FRAMES = DATA_W / (FRAME_OCT * 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sync_q;
    logic [NP-1:0]       base_q, base_d;
    logic [DATA_W-1:0]   link_data_q;
    logic                link_valid_q;
    logic [15:0]         dunf_count_q;

    logic                sync_edge;
    logic                underflow;
    logic [DATA_W-1:0]   ramp_vec;
    logic [DATA_W-1:0]   src_vec;
    logic [DATA_W-1:0]   packed_vec;
    logic [DATA_W-1:0]   beat_d;

    assign sync_edge   = dac_external_sync & ~sync_q;
    assign dac_ready   = link_ready & (state_q == ST_RUN) & (data_sel == 2'd0);
    assign underflow   = dac_ready & ~dac_valid;
    assign dac_dunf    = underflow;
    assign sync_status = (state_q == ST_RUN);
    assign link_valid  = link_valid_q;
    assign link_data   = link_data_q;
    assign dunf_count  = dunf_count_q;

    always_comb begin
        state_d = state_q;
        if (sync_disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (sync_arm) state_d = ext_sync_en ? ST_ARMED : ST_RUN;
                ST_ARMED: if (sync_edge) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ramp_vec = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
                ramp_vec[(c*DATA_PATH_WIDTH + s)*NP +: NP] = base_q + NP'(s);
            end
        end
    end

    assign src_vec = (data_sel == 2'd2) ? ramp_vec : dac_data;

    // Frame octet j (MSB first) of frame k lands on lane j/F, lane octet k*F + j%F.
    always_comb begin
        packed_vec = '0;
        for (int k = 0; k < NUM_FRAMES; k++) begin
            for (int j = 0; j < FRAME_OCT; j++) begin
                packed_vec[((j / F)*OCTETS_PER_BEAT + k*F + (j % F))*8 +: 8] =
                    src_vec[((j / CONV_OCT)*DATA_PATH_WIDTH + k*SAMPLES_PER_FRAME
                             + (j % CONV_OCT) / NP_OCT)*NP
                            + (NP_OCT - 1 - (j % NP_OCT))*8 +: 8];
            end
        end
    end

    always_comb begin
        beat_d = '0;
        if (state_q == ST_RUN && ((data_sel == 2'd0 && dac_valid) || data_sel == 2'd2)) begin
            beat_d = packed_vec;
        end
    end

    // Ramp base restarts on every entry to RUN and only steps on beats actually loaded.
    always_comb begin
        base_d = base_q;
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            base_d = '0;
        end else if (link_ready && state_q == ST_RUN && data_sel == 2'd2) begin
            base_d = base_q + NP'(DATA_PATH_WIDTH);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            sync_q       <= 1'b0;
            base_q       <= '0;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
            dunf_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= dac_external_sync;
            base_q       <= base_d;
            link_valid_q <= 1'b1;
            if (link_ready) begin
                link_data_q <= beat_d;
            end
            if (underflow && dunf_count_q != 16'hFFFF) begin
                dunf_count_q <= dunf_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_framer.sv
// Directed bench for the TX framer; a second instance runs the ramp/wrap sequence
// in parallel so the long underflow-saturation run and the ramp wrap overlap.
module tb_ad_ip_jesd204_tpl_dac_framer;

    localparam int DW = 128;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, dac_valid, dac_ready, link_ready, link_valid;
    logic [DW-1:0] dac_data, link_data;
    logic [1:0]    data_sel;
    logic          ext_sync_en, sync_arm, sync_disarm, dac_external_sync;
    logic          sync_status, dac_dunf;
    logic [15:0]   dunf_count;

    logic          r_resetn, r_dac_valid, r_dac_ready, r_link_ready, r_link_valid;
    logic [DW-1:0] r_dac_data, r_link_data;
    logic [1:0]    r_data_sel;
    logic          r_ext_sync_en, r_sync_arm, r_sync_disarm, r_dac_external_sync;
    logic          r_sync_status, r_dac_dunf;
    logic [15:0]   r_dunf_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DW-1:0] P1   = 128'hEF01ABCD_44443333_22221111_56781234;
    localparam logic [DW-1:0] EXP1 = 128'h01EFCDAB_44443333_22221111_78563412;
    localparam logic [DW-1:0] P2   = 128'hD2D3D0D1_C2C3C0C1_B2B3B0B1_A2A3A0A1;
    localparam logic [DW-1:0] EXP2 = 128'hD3D2D1D0_C3C2C1C0_B3B2B1B0_A3A2A1A0;
    localparam logic [DW-1:0] R01  = {4{32'h01000000}};
    localparam logic [DW-1:0] R23  = {4{32'h03000200}};
    localparam logic [DW-1:0] R45  = {4{32'h05000400}};
    localparam logic [DW-1:0] RFE  = {4{32'hFFFFFEFF}};

    ad_ip_jesd204_tpl_dac_framer u_dut (
        .clk               (clk),
        .resetn            (resetn),
        .dac_valid         (dac_valid),
        .dac_ready         (dac_ready),
        .dac_data          (dac_data),
        .link_ready        (link_ready),
        .link_valid        (link_valid),
        .link_data         (link_data),
        .data_sel          (data_sel),
        .ext_sync_en       (ext_sync_en),
        .sync_arm          (sync_arm),
        .sync_disarm       (sync_disarm),
        .dac_external_sync (dac_external_sync),
        .sync_status       (sync_status),
        .dac_dunf          (dac_dunf),
        .dunf_count        (dunf_count)
    );

    ad_ip_jesd204_tpl_dac_framer u_ramp (
        .clk               (clk),
        .resetn            (r_resetn),
        .dac_valid         (r_dac_valid),
        .dac_ready         (r_dac_ready),
        .dac_data          (r_dac_data),
        .link_ready        (r_link_ready),
        .link_valid        (r_link_valid),
        .link_data         (r_link_data),
        .data_sel          (r_data_sel),
        .ext_sync_en       (r_ext_sync_en),
        .sync_arm          (r_sync_arm),
        .sync_disarm       (r_sync_disarm),
        .dac_external_sync (r_dac_external_sync),
        .sync_status       (r_sync_status),
        .dac_dunf          (r_dac_dunf),
        .dunf_count        (r_dunf_count)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_main();
        dac_data = P1; dac_valid = 1'b1; link_ready = 1'b1; data_sel = 2'd0;
        ext_sync_en = 1'b0; sync_arm = 1'b1;
        #1 check("ready_idle", dac_ready, 0);
        tick(); sync_arm = 1'b0;
        check("status_run", sync_status, 1);
        check("beat_at_arm", link_data, 0);
        check("ready_run", dac_ready, 1);
        tick(); check("frame_p1", link_data, EXP1);
        dac_data = P2;
        tick(); check("frame_p2", link_data, EXP2);

        dac_data = P1;
        tick(); check("bp_load", link_data, EXP1);
        link_ready = 1'b0; dac_data = P2;
        #1 check("bp_ready_low", dac_ready, 0);
        tick(); check("bp_hold1", link_data, EXP1);
        tick(); check("bp_hold2", link_data, EXP1);
        link_ready = 1'b1;
        #1 check("bp_ready_high", dac_ready, 1);
        tick(); check("bp_resume", link_data, EXP2);

        dac_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("dunf_pulse", dac_dunf, 1);
            tick(); check("dunf_zero_beat", link_data, 0);
        end
        dac_valid = 1'b1; dac_data = P1;
        #1 check("dunf_quiet", dac_dunf, 0);
        check("dunf_count3", dunf_count, 3);
        tick(); check("after_dunf", link_data, EXP1);

        sync_disarm = 1'b1;
        tick(); sync_disarm = 1'b0;
        check("disarm_status", sync_status, 0);
        check("disarm_ready", dac_ready, 0);
        tick(); check("idle_zero", link_data, 0);

        sync_arm = 1'b1; sync_disarm = 1'b1;
        tick(); sync_arm = 1'b0; sync_disarm = 1'b0;
        check("arm_disarm_same", sync_status, 0);
        tick(); check("arm_disarm_stay", sync_status, 0);

        ext_sync_en = 1'b1; dac_external_sync = 1'b1;
        tick(); dac_external_sync = 1'b0;
        tick(); check("sync_idle_ignored", sync_status, 0);
        dac_data = P2; sync_arm = 1'b1;
        tick(); sync_arm = 1'b0;
        check("armed_status", sync_status, 0);
        check("armed_ready", dac_ready, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("armed_zero", link_data, 0);
            check("armed_wait", sync_status, 0);
        end
        dac_external_sync = 1'b1;
        tick(); check("sync_edge_run", sync_status, 1);
        check("sync_first_ready", dac_ready, 1);
        tick(); check("sync_first_beat", link_data, EXP2);

        dac_valid = 1'b0;
        repeat (65540) @(posedge clk);
        #1 check("dunf_saturate", dunf_count, 16'hFFFF);
        check("dunf_pulse_sat", dac_dunf, 1);

        dac_valid = 1'b1; dac_data = P1;
        tick(); check("pre_reset_beat", link_data, EXP1);
        #2 resetn = 1'b0;
        #1 check("rst_link_valid", link_valid, 0);
        check("rst_link_data", link_data, 0);
        check("rst_dunf_count", dunf_count, 0);
        check("rst_status", sync_status, 0);
        ext_sync_en = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        tick(); check("post_rst_valid", link_valid, 1);
        check("post_rst_zero", link_data, 0);
    endtask

    task automatic run_ramp();
        r_data_sel = 2'd2; r_link_ready = 1'b1; r_sync_arm = 1'b1;
        tick(); r_sync_arm = 1'b0;
        check("ramp_status", r_sync_status, 1);
        check("ramp_no_ready", r_dac_ready, 0);
        tick(); check("ramp_01", r_link_data, R01);
        tick(); check("ramp_23", r_link_data, R23);
        r_link_ready = 1'b0;
        tick(); check("ramp_stall1", r_link_data, R23);
        tick(); check("ramp_stall2", r_link_data, R23);
        r_link_ready = 1'b1;
        tick(); check("ramp_45", r_link_data, R45);
        repeat (32764) @(posedge clk);
        tick(); check("ramp_fffe", r_link_data, RFE);
        tick(); check("ramp_wrap", r_link_data, R01);
        check("ramp_no_dunf", r_dunf_count, 0);
        r_sync_disarm = 1'b1;
        tick(); r_sync_disarm = 1'b0; r_sync_arm = 1'b1;
        tick(); r_sync_arm = 1'b0;
        tick(); check("ramp_rearm_base", r_link_data, R01);
    endtask

    initial begin
        resetn = 1'b0; dac_valid = 1'b1; dac_data = '0; link_ready = 1'b1; data_sel = 2'd0;
        ext_sync_en = 1'b0; sync_arm = 1'b0; sync_disarm = 1'b0; dac_external_sync = 1'b0;
        r_resetn = 1'b0; r_dac_valid = 1'b0; r_dac_data = '0; r_link_ready = 1'b1;
        r_data_sel = 2'd0; r_ext_sync_en = 1'b0; r_sync_arm = 1'b0; r_sync_disarm = 1'b0;
        r_dac_external_sync = 1'b0;
        #12;
        check("reset_link_valid", link_valid, 0);
        check("reset_link_data", link_data, 0);
        check("reset_ready", dac_ready, 0);
        check("reset_status", sync_status, 0);
        check("reset_dunf", dac_dunf, 0);
        check("reset_dunf_count", dunf_count, 0);
        @(posedge clk); #1;
        resetn = 1'b1; r_resetn = 1'b1;
        tick();
        check("valid_after_reset", link_valid, 1);
        check("zero_after_reset", link_data, 0);
        fork
            run_main();
            run_ramp();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_framer.md
Name: ad_ip_jesd204_tpl_dac_framer

Overview:
Transmit-side JESD204 transport-layer framer. It accepts per-channel DAC samples from the DMA and packs them into lane octets for the JESD204 TX link layer. It also provides sync arming/gating, a zero/ramp test-pattern source and underflow detection. It sits between the DMA/upack and the TX link layer, in the link_clk domain.

Parameters:
NUM_LANES, 4, number of JESD lanes (L)
NUM_CHANNELS, 4, number of converters (M)
SAMPLES_PER_FRAME, 1, samples per converter per frame (S)
BITS_PER_SAMPLE, 16, NP; must be a multiple of 8
OCTETS_PER_BEAT, 4, octets per lane per clk
DATA_PATH_WIDTH, 2, samples per channel per beat = OCTETS_PER_BEAT*8*NUM_LANES/NUM_CHANNELS/BITS_PER_SAMPLE

Ports:
clk  in  1  link clock (line-rate/40); all logic on rising edge
resetn  in  1  asynchronous active-low reset
dac_valid  in  1  DMA beat valid
dac_ready  out  1  DMA beat accept
dac_data  in  NUM_LANES*8*OCTETS_PER_BEAT  channel c sample s at bits [(c*DATA_PATH_WIDTH+s)*BITS_PER_SAMPLE +: BITS_PER_SAMPLE]
link_ready  in  1  link layer accepts beat
link_valid  out  1  beat valid to link layer
link_data  out  NUM_LANES*8*OCTETS_PER_BEAT  lane l octet o at [(l*OCTETS_PER_BEAT+o)*8 +: 8]; o=0 is first on the wire
data_sel  in  2  0=DMA, 1=zero, 2=ramp, 3=zero
ext_sync_en  in  1  wait for external sync edge when arming
sync_arm  in  1  single-cycle arm pulse
sync_disarm  in  1  single-cycle stop pulse
dac_external_sync  in  1  external sync, already synchronous to clk
sync_status  out  1  1 while in RUN
dac_dunf  out  1  single-cycle underflow pulse
dunf_count  out  16  saturating underflow count; cleared only by reset

Behaviour:
- Reset values: state=IDLE, link_valid=0, link_data=0, dac_ready=0, sync_status=0, dac_dunf=0, dunf_count=0, ramp base=0, sync edge register=0.
- link_valid goes 1 on the first clk after resetn deasserts and stays 1 thereafter.
- Output register loads a new beat only when link_ready=1; otherwise it holds.
- FSM:
  - IDLE: beat=zeros. On sync_arm: go to ARMED if ext_sync_en=1, else RUN.
  - ARMED: beat=zeros. Go to RUN on a rising edge of dac_external_sync (registered previous value, 0->1).
  - RUN: beat from source selected by data_sel.
  - sync_disarm in any state: go to IDLE next cycle.
  - sync_arm and sync_disarm in the same cycle: disarm wins.
  - Sync edge in IDLE is ignored.
- dac_ready = link_ready & (state==RUN) & (data_sel==0), combinational. A DMA beat transfers when dac_valid & dac_ready.
- Underflow: dac_ready=1 and dac_valid=0. Response: load a zero beat, pulse dac_dunf the same cycle, increment dunf_count; it saturates at 0xFFFF.
- Ramp source: each channel emits base+s for s=0..DATA_PATH_WIDTH-1, modulo 2^BITS_PER_SAMPLE. base advances by DATA_PATH_WIDTH per loaded beat. base resets to 0 on entry to RUN.
- Framing, per frame k = 0 .. OCTETS_PER_BEAT*NUM_LANES*8/(NUM_CHANNELS*SAMPLES_PER_FRAME*BITS_PER_SAMPLE)-1:
  - Frame vector = concatenation, MSB first, of converter 0..M-1 and, within each converter, samples k*S..k*S+S-1.
  - F = M*S*NP/(8*L). Frame octet j (j=0 is MSB) goes to lane j/F, octet k*F + j%F.
- Latency: dac_data accepted at edge N appears on link_data after edge N (one register stage).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first beat after reset is zeros.

Test Plan:
- Framing, default params, data_sel=0, ext_sync_en=0, arm, link_ready=1; ch0 s0=0x1234, s1=0x5678 -> lane0 octets 0..3 = 0x12,0x34,0x56,0x78, i.e. link_data[31:0]=0x78563412; ch3 s0=0xABCD -> lane3 octet0=0xAB.
- Sync gating: ext_sync_en=1, sync_arm -> sync_status=0, link_data=0, dac_ready=0. External sync held low, then 0->1 -> sync_status=1 one cycle later and the first DMA beat is accepted.
- Backpressure: toggle link_ready 1,0,0,1 with dac_valid=1 -> dac_ready follows link_ready, link_data is held while link_ready=0, no beat is lost or duplicated.
- Underflow: in RUN, drop dac_valid for 3 cycles -> 3 zero beats, dac_dunf pulses 3 times, dunf_count=3. Force 70000 underflows -> dunf_count=0xFFFF.
- Ramp: data_sel=2, arm -> ch0 samples 0,1 then 2,3 on successive beats. Stalling link_ready does not advance base. Wrap at 0xFFFF -> 0x0000.
- Disarm/simultaneous/reset: sync_arm and sync_disarm in the same cycle -> stays IDLE. Assert resetn=0 mid-stream -> link_valid=0, link_data=0 immediately, dunf_count=0.
